// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract with carry-in and flags; WIDTH is split into STAGES slices, carry registered between them.
// Latency STAGES cycles, one op per cycle; a single global stall (advance) freezes every stage while the output is held.
module pipelined_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);
   localparam int SW   = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   // Stage k inputs (x_i) come from stage k-1 registers (x_q); stage 0 takes the ports.
   logic [WIDTH-1:0] a_i [STAGES];
   logic [WIDTH-1:0] b_i [STAGES];
   logic [WIDTH-1:0] s_i [STAGES];
   logic             c_i [STAGES];
   logic             z_i [STAGES];
   logic             v_i [STAGES];

   logic [WIDTH-1:0] s_q [STAGES];
   logic             c_q [STAGES];
   logic             z_q [STAGES];
   logic             v_q [STAGES];
   logic             ovf_q;

   logic [SW:0]      slice [STAGES];
   logic [WIDTH-1:0] s_d   [STAGES];
   logic [WIDTH-1:0] b_eff;
   logic             ovf_d;
   logic             advance;

   assign advance  = !v_q[LAST] || out_ready;
   assign in_ready = advance;
   assign b_eff    = b ^ {WIDTH{op[0]}};

   // Operand skew registers exist only between stages, so a single-stage unit has none.
   if (STAGES > 1) begin : g_skew
      logic [WIDTH-1:0] a_q [STAGES-1];
      logic [WIDTH-1:0] b_q [STAGES-1];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int k = 0; k < STAGES - 1; k++) begin
               a_q[k] <= '0;
               b_q[k] <= '0;
            end
         end else if (advance) begin
            for (int k = 0; k < STAGES - 1; k++) begin
               a_q[k] <= a_i[k];
               b_q[k] <= b_i[k];
            end
         end
      end

      always_comb begin
         a_i[0] = a;
         b_i[0] = b_eff;
         for (int k = 1; k < STAGES; k++) begin
            a_i[k] = a_q[k-1];
            b_i[k] = b_q[k-1];
         end
      end
   end else begin : g_noskew
      always_comb begin
         a_i[0] = a;
         b_i[0] = b_eff;
      end
   end

   always_comb begin
      s_i[0] = '0;
      c_i[0] = op[1] ? cin : op[0];
      z_i[0] = 1'b1;
      v_i[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         s_i[k] = s_q[k-1];
         c_i[k] = c_q[k-1];
         z_i[k] = z_q[k-1];
         v_i[k] = v_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         slice[k] = {1'b0, a_i[k][k*SW +: SW]} + {1'b0, b_i[k][k*SW +: SW]}
                  + {{SW{1'b0}}, c_i[k]};
         s_d[k] = s_i[k];
         s_d[k][k*SW +: SW] = slice[k][SW-1:0];
      end
      // Carry into the MSB recovered from the MSB sum bit: a ^ b ^ s.
      ovf_d = a_i[LAST][WIDTH-1] ^ b_i[LAST][WIDTH-1] ^ slice[LAST][SW-1] ^ slice[LAST][SW];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
            z_q[k] <= 1'b0;
            v_q[k] <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            s_q[k] <= s_d[k];
            c_q[k] <= slice[k][SW];
            z_q[k] <= z_i[k] && (slice[k][SW-1:0] == '0);
            v_q[k] <= v_i[k];
         end
         ovf_q <= ovf_d;
      end
   end

   assign out_valid = v_q[LAST];
   assign sum       = s_q[LAST];
   assign carry     = c_q[LAST];
   assign overflow  = ovf_q;
   assign zero      = z_q[LAST];
   assign negative  = s_q[LAST][WIDTH-1];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: 32/4, 16/2 and 8/1 instances share stimulus; one is selected at a time.
module tb_pipelined_addsub;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid;
   int          sel;
   logic [31:0] a, b;
   logic [1:0]  op;
   logic        cin;
   logic        out_ready;

   logic        iv0, iv1, iv2, ir0, ir1, ir2, ov0, ov1, ov2;
   logic [31:0] s0;
   logic [15:0] s1;
   logic [7:0]  s2;
   logic        c0, c1, c2, f0, f1, f2, z0, z1, z2, n0, n1, n2;

   assign iv0 = in_valid && (sel == 0);
   assign iv1 = in_valid && (sel == 1);
   assign iv2 = in_valid && (sel == 2);

   pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b), .op(op), .cin(cin),
      .out_valid(ov0), .out_ready(out_ready), .sum(s0), .carry(c0), .overflow(f0), .zero(z0), .negative(n0));
   pipelined_addsub #(.WIDTH(16), .STAGES(2)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a[15:0]), .b(b[15:0]), .op(op), .cin(cin),
      .out_valid(ov1), .out_ready(out_ready), .sum(s1), .carry(c1), .overflow(f1), .zero(z1), .negative(n1));
   pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a[7:0]), .b(b[7:0]), .op(op), .cin(cin),
      .out_valid(ov2), .out_ready(out_ready), .sum(s2), .carry(c2), .overflow(f2), .zero(z2), .negative(n2));

   logic        m_valid, m_ready, m_c, m_v, m_z, m_n;
   logic [31:0] m_sum;
   always_comb begin
      m_valid = ov0; m_ready = ir0; m_sum = s0; m_c = c0; m_v = f0; m_z = z0; m_n = n0;
      if (sel == 1) begin
         m_valid = ov1; m_ready = ir1; m_sum = {16'h0, s1}; m_c = c1; m_v = f1; m_z = z1; m_n = n1;
      end else if (sel == 2) begin
         m_valid = ov2; m_ready = ir2; m_sum = {24'h0, s2}; m_c = c2; m_v = f2; m_z = z2; m_n = n2;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference for the 32-bit unit: {overflow, carry, zero, negative, sum}.
   function automatic logic [35:0] model(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                                         input logic ci);
      logic [31:0] be;
      logic        c_in, v;
      logic [32:0] r;
      be = o[0] ? ~bb : bb;
      case (o)
         2'b00:   c_in = 1'b0;
         2'b01:   c_in = 1'b1;
         default: c_in = ci;
      endcase
      r = {1'b0, aa} + {1'b0, be} + {32'h0, c_in};
      v = (aa[31] == be[31]) && (r[31] != aa[31]);
      return {v, r[32], r[31:0] == 32'h0, r[31], r[31:0]};
   endfunction

   task automatic run_op(input int s, input string tag, input logic [1:0] o, input logic [31:0] aa,
                         input logic [31:0] bb, input logic ci, input logic [31:0] e_sum,
                         input logic e_c, input logic e_v, input logic e_z, input logic e_n, input int e_lat);
      int lat;
      sel = s;
      @(negedge clk);
      op = o; a = aa; b = bb; cin = ci; in_valid = 1'b1; out_ready = 1'b1;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
         in_valid = 1'b0;
      end while (!m_valid && lat < 20);
      check({tag, "_lat"}, 64'(lat), 64'(e_lat));
      check({tag, "_sum"}, m_sum, e_sum);
      check({tag, "_carry"}, m_c, e_c);
      check({tag, "_ovf"}, m_v, e_v);
      check({tag, "_zero"}, m_z, e_z);
      check({tag, "_neg"}, m_n, e_n);
      @(posedge clk);
      #1;
   endtask

   task automatic stream(input int nops, input bit rnd, output int cycles);
      logic [35:0] q[$];
      logic [35:0] cur, held, exp;
      int          sent, got, cyc;
      logic        stall;
      sent = 0; got = 0; cyc = 0; stall = 1'b0; held = '0;
      sel = 0;
      while (got < nops && cyc < 400) begin
         @(negedge clk);
         out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (sent < nops) begin
            in_valid = 1'b1;
            op  = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom_range(0, 1));
         end else begin
            in_valid = 1'b0;
         end
         #1;
         cur = {m_v, m_c, m_z, m_n, m_sum};
         if (stall) check("stall_hold", cur, held);
         if (in_valid && m_ready) begin
            q.push_back(model(op, a, b, cin));
            sent++;
         end
         if (m_valid && out_ready) begin
            if (q.size() == 0) begin
               check("stream_dup", 1, 0);
            end else begin
               exp = q.pop_front();
               check("stream_res", cur, exp);
            end
            got++;
         end
         stall = m_valid && !out_ready;
         held  = cur;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      if (got < nops) check("stream_timeout", 64'(got), 64'(nops));
      check("stream_left", 64'(q.size()), 0);
      cycles = cyc;
   endtask

   initial begin
      int   cycles;
      logic seen;
      rst_n = 1'b0; in_valid = 1'b0; sel = 0; out_ready = 1'b1;
      a = '0; b = '0; op = 2'b00; cin = 1'b0;
      #1;
      check("rst_valid", m_valid, 0);
      check("rst_ready", m_ready, 1);
      check("rst_sum", m_sum, 0);
      check("rst_flags", {m_c, m_v, m_z, m_n}, 0);
      #21 rst_n = 1'b1;

      run_op(0, "w32_add_ovf", 2'b00, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 0, 1, 0, 1, 4);
      run_op(0, "w32_sub_neg", 2'b01, 32'h5, 32'h7, 1'b0, 32'hFFFFFFFE, 0, 0, 0, 1, 4);
      run_op(0, "w32_sub_ovf", 2'b01, 32'h80000000, 32'h1, 1'b0, 32'h7FFFFFFF, 1, 1, 0, 0, 4);
      run_op(0, "w32_adc_zero", 2'b10, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 1, 0, 1, 0, 4);
      run_op(0, "w32_sbb", 2'b11, 32'd10, 32'd3, 1'b0, 32'd6, 1, 0, 0, 0, 4);
      run_op(1, "w16_add_ovf", 2'b00, 32'h7FFF, 32'h1, 1'b0, 32'h8000, 0, 1, 0, 1, 2);
      run_op(1, "w16_adc_zero", 2'b10, 32'hFFFF, 32'h0, 1'b1, 32'h0, 1, 0, 1, 0, 2);
      run_op(2, "w8_add_ovf", 2'b00, 32'h7F, 32'h1, 1'b0, 32'h80, 0, 1, 0, 1, 1);
      run_op(2, "w8_adc_zero", 2'b10, 32'hFF, 32'h0, 1'b1, 32'h0, 1, 0, 1, 0, 1);

      stream(16, 1'b1, cycles);
      stream(8, 1'b0, cycles);
      check("burst_cycles", 64'(cycles), 64'd12);

      // Fill the pipe behind a stalled output, then reset between edges.
      sel = 0;
      @(negedge clk);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; op = 2'b00; a = 32'(i + 1); b = 32'h1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("pre_rst_valid", m_valid, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", m_valid, 0);
      check("mid_rst_ready", m_ready, 1);
      check("mid_rst_sum", m_sum, 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (m_valid) seen = 1'b1;
      end
      check("post_rst_idle", seen, 0);
      run_op(0, "w32_post_rst", 2'b00, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 0, 0, 0, 0, 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
